// File: rtl/vu_bank_seq_pkg.sv
// Shared widths, write-select encoding and operand-latch bit positions for the
// Banked8 VXU per-bank port controller.
package vu_bank_seq_pkg;

    localparam int unsigned VB_REGLEN_W = 8;   // bank register address width
    localparam int unsigned VB_VLEN_W   = 8;   // element count width
    localparam int unsigned VB_NWR      = 5;   // write requesters
    localparam int unsigned VB_WSEL_W   = 3;   // wsel width
    localparam int unsigned VB_NOPND_W  = 2;   // operand count width
    localparam int unsigned VB_ROPL_W   = 2;   // operand latch enables

    // Write-select encoding (also the arbiter priority order).
    localparam logic [VB_WSEL_W-1:0] WSEL_WBL0 = 3'd0;
    localparam logic [VB_WSEL_W-1:0] WSEL_WBL1 = 3'd1;
    localparam logic [VB_WSEL_W-1:0] WSEL_WBL2 = 3'd2;
    localparam logic [VB_WSEL_W-1:0] WSEL_WBL3 = 3'd3;
    localparam logic [VB_WSEL_W-1:0] WSEL_VIU  = 3'd4;

    // roplen bit positions: operand 0 goes to ropl0, operand 1 to ropl1.
    localparam int unsigned ROPL0_BIT = 0;
    localparam int unsigned ROPL1_BIT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } seq_state_t;

    // An operand count of zero behaves as a single operand.
    function automatic logic [VB_NOPND_W-1:0] norm_nopnd(input logic [VB_NOPND_W-1:0] n);
        return (n == '0) ? VB_NOPND_W'(1) : n;
    endfunction

endpackage

// File: rtl/vu_bank_wport_arb.sv
// Fixed-priority write-port arbiter (lowest requester index wins), combinational.
// Ports:
//   wreq     - per-requester write request
//   waddr_in - per-requester write address, requester i at slice i
//   wgnt     - one-hot grant to the winner
//   wen      - any request present
//   waddr    - winner's address (0 when idle)
//   wsel     - winner's index (0 when idle)
module vu_bank_wport_arb #(
    parameter int unsigned NWR      = 5,
    parameter int unsigned REGLEN_W = 8,
    parameter int unsigned WSEL_W   = 3
) (
    input  logic [NWR-1:0]          wreq,
    input  logic [NWR*REGLEN_W-1:0] waddr_in,
    output logic [NWR-1:0]          wgnt,
    output logic                    wen,
    output logic [REGLEN_W-1:0]     waddr,
    output logic [WSEL_W-1:0]       wsel
);

    // Scan from the highest index down so the lowest active requester is the final winner.
    always_comb begin
        wgnt  = '0;
        wsel  = '0;
        waddr = '0;
        wen   = |wreq;
        for (int i = NWR - 1; i >= 0; i--) begin
            if (wreq[i]) begin
                wgnt  = NWR'(1) << i;
                wsel  = WSEL_W'(i);
                waddr = waddr_in[i*REGLEN_W +: REGLEN_W];
            end
        end
    end

endmodule

// File: rtl/vu_bank_seq.sv
// Per-bank port controller for the Banked8 VXU 1R1W register file bank.
// The read side walks one descriptor over all elements and operands, issuing
// ren/raddr every cycle with no bubbles; a one-stage delay pipeline turns each
// read into the matching operand-latch enable or fire one cycle later, when the
// synchronous read data is valid. The write side is a fixed-priority arbiter.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   op_valid/op_ready            - descriptor handshake
//   op_nopnd, op_addr0..2,
//   op_stride, op_vlen           - descriptor fields
//   ren, raddr                   - regfile read port
//   roplen                       - operand latch enables (bit0 ropl0, bit1 ropl1)
//   fire, fire_last              - operand set complete / last element
//   wreq, waddr_in               - write requests and per-requester addresses
//   wgnt, wen, waddr, wsel       - write grant and regfile write port
module vu_bank_seq
    import vu_bank_seq_pkg::*;
#(
    parameter int unsigned REGLEN_W = VB_REGLEN_W,
    parameter int unsigned VLEN_W   = VB_VLEN_W,
    parameter int unsigned NWR      = VB_NWR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [VB_NOPND_W-1:0]   op_nopnd,
    input  logic [REGLEN_W-1:0]     op_addr0,
    input  logic [REGLEN_W-1:0]     op_addr1,
    input  logic [REGLEN_W-1:0]     op_addr2,
    input  logic [REGLEN_W-1:0]     op_stride,
    input  logic [VLEN_W-1:0]       op_vlen,
    output logic                    ren,
    output logic [REGLEN_W-1:0]     raddr,
    output logic [VB_ROPL_W-1:0]    roplen,
    output logic                    fire,
    output logic                    fire_last,
    input  logic [NWR-1:0]          wreq,
    input  logic [NWR*REGLEN_W-1:0] waddr_in,
    output logic [NWR-1:0]          wgnt,
    output logic                    wen,
    output logic [REGLEN_W-1:0]     waddr,
    output logic [VB_WSEL_W-1:0]    wsel
);

    seq_state_t              state;
    logic [VB_NOPND_W-1:0]   nopnd_q;
    logic [VB_NOPND_W-1:0]   opnd_q;
    logic [VLEN_W-1:0]       vlen_q;
    logic [VLEN_W-1:0]       elem_q;
    logic [REGLEN_W-1:0]     stride_q;
    logic [REGLEN_W-1:0]     a_q [3];

    logic accept;
    logic last_opnd;
    logic last_elem;

    // opnd_q/elem_q always describe the read currently on ren/raddr.
    assign accept    = op_valid && op_ready;
    assign last_opnd = (opnd_q == nopnd_q - VB_NOPND_W'(1));
    assign last_elem = (elem_q == vlen_q - VLEN_W'(1));

    // Read sequencer: state, running addresses, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_ready  <= 1'b1;
            ren       <= 1'b0;
            raddr     <= '0;
            roplen    <= '0;
            fire      <= 1'b0;
            fire_last <= 1'b0;
            nopnd_q   <= VB_NOPND_W'(1);
            opnd_q    <= '0;
            vlen_q    <= '0;
            elem_q    <= '0;
            stride_q  <= '0;
            for (int k = 0; k < 3; k++) begin
                a_q[k] <= '0;
            end
        end else begin
            // Delay pipeline: acts on the read issued this cycle, so it keeps
            // producing the trailing fire after the FSM has gone back to IDLE.
            roplen[ROPL0_BIT] <= ren && (opnd_q == 2'd0) && (nopnd_q >= 2'd2);
            roplen[ROPL1_BIT] <= ren && (opnd_q == 2'd1) && (nopnd_q == 2'd3);
            fire              <= ren && last_opnd;
            fire_last         <= ren && last_opnd && last_elem;

            case (state)
                ST_IDLE: begin
                    ren <= 1'b0;
                    if (accept) begin
                        nopnd_q  <= norm_nopnd(op_nopnd);
                        vlen_q   <= op_vlen;
                        stride_q <= op_stride;
                        a_q[0]   <= op_addr0;
                        a_q[1]   <= op_addr1;
                        a_q[2]   <= op_addr2;
                        opnd_q   <= '0;
                        elem_q   <= '0;
                        // Zero-length ops are consumed without touching the read port.
                        if (op_vlen != '0) begin
                            state    <= ST_READ;
                            op_ready <= 1'b0;
                            ren      <= 1'b1;
                            raddr    <= op_addr0;
                        end
                    end
                end
                ST_READ: begin
                    if (!last_opnd) begin
                        opnd_q <= opnd_q + VB_NOPND_W'(1);
                        raddr  <= a_q[opnd_q + VB_NOPND_W'(1)];
                    end else if (last_elem) begin
                        state    <= ST_IDLE;
                        op_ready <= 1'b1;
                        ren      <= 1'b0;
                        opnd_q   <= '0;
                    end else begin
                        // Next element: advance every base (wrapping) and issue operand 0.
                        opnd_q <= '0;
                        elem_q <= elem_q + VLEN_W'(1);
                        for (int k = 0; k < 3; k++) begin
                            a_q[k] <= a_q[k] + stride_q;
                        end
                        raddr <= a_q[0] + stride_q;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                    ren      <= 1'b0;
                end
            endcase
        end
    end

    // Write port arbitration, independent of the read side.
    vu_bank_wport_arb #(
        .NWR      (NWR),
        .REGLEN_W (REGLEN_W),
        .WSEL_W   (VB_WSEL_W)
    ) u_wport_arb (
        .wreq     (wreq),
        .waddr_in (waddr_in),
        .wgnt     (wgnt),
        .wen      (wen),
        .waddr    (waddr),
        .wsel     (wsel)
    );

endmodule

// File: tb/tb_vu_bank_seq.sv
// Bench for vu_bank_seq: scoreboard of expected reads/fires built from a
// descriptor model, plus per-scenario cycle checks and write-arbiter checks.
module tb_vu_bank_seq;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_nopnd;
    logic [7:0]  op_addr0, op_addr1, op_addr2, op_stride, op_vlen;
    logic        ren;
    logic [7:0]  raddr;
    logic [1:0]  roplen;
    logic        fire, fire_last;
    logic [4:0]  wreq;
    logic [39:0] waddr_in;
    logic [4:0]  wgnt;
    logic        wen;
    logic [7:0]  waddr;
    logic [2:0]  wsel;

    int checks;
    int errors;

    typedef struct packed {
        logic [7:0] addr;
        logic [1:0] ropl;
    } rd_t;

    rd_t        exp_rd[$];
    bit         exp_fl[$];
    logic [1:0] pend_ropl;
    bit         mon_en;

    vu_bank_seq dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_nopnd  (op_nopnd),
        .op_addr0  (op_addr0),
        .op_addr1  (op_addr1),
        .op_addr2  (op_addr2),
        .op_stride (op_stride),
        .op_vlen   (op_vlen),
        .ren       (ren),
        .raddr     (raddr),
        .roplen    (roplen),
        .fire      (fire),
        .fire_last (fire_last),
        .wreq      (wreq),
        .waddr_in  (waddr_in),
        .wgnt      (wgnt),
        .wen       (wen),
        .waddr     (waddr),
        .wsel      (wsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every read and fire is matched against the model.
    always @(negedge clk) begin : mon
        rd_t r;
        if (mon_en) begin
            checks++;
            if (roplen !== pend_ropl) begin
                errors++;
                $display("FAIL roplen got %b exp %b at %0t", roplen, pend_ropl, $time);
            end
            pend_ropl = 2'b00;
            if (ren === 1'b1) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ren raddr %0d at %0t", raddr, $time);
                end else begin
                    r = exp_rd.pop_front();
                    if (raddr !== r.addr) begin
                        errors++;
                        $display("FAIL raddr got %0d exp %0d at %0t", raddr, r.addr, $time);
                    end
                    pend_ropl = r.ropl;
                end
            end
            if (fire === 1'b1) begin
                checks++;
                if (exp_fl.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_fire at %0t", $time);
                end else if (fire_last !== exp_fl.pop_front()) begin
                    errors++;
                    $display("FAIL fire_last got %b (wrong element) at %0t", fire_last, $time);
                end
            end else if (fire_last === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL fire_last_without_fire at %0t", $time);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Descriptor model: expected read addresses, latch enables and fires.
    task automatic push_op(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int st, input int vl);
        logic [7:0] base [3];
        rd_t        r;
        int         ne;
        ne      = (n == 0) ? 1 : n;
        base[0] = b0;
        base[1] = b1;
        base[2] = b2;
        for (int e = 0; e < vl; e++) begin
            for (int k = 0; k < ne; k++) begin
                r.addr = 8'(int'(base[k]) + e * st);
                r.ropl = (k == 0 && ne >= 2) ? 2'b01 : ((k == 1 && ne == 3) ? 2'b10 : 2'b00);
                exp_rd.push_back(r);
                if (k == ne - 1) exp_fl.push_back(e == vl - 1);
            end
        end
    endtask

    task automatic drive_op(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int st, input int vl);
        op_nopnd  = 2'(n);
        op_addr0  = b0;
        op_addr1  = b1;
        op_addr2  = b2;
        op_stride = 8'(st);
        op_vlen   = 8'(vl);
        op_valid  = 1'b1;
    endtask

    task automatic wait_idle;
        bit done;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (op_ready && !ren && !fire && exp_rd.size() == 0 && exp_fl.size() == 0) done = 1;
            tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL idle_timeout pending reads %0d fires %0d", exp_rd.size(), exp_fl.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        mon_en = 0;
        tick();
        tick();
        @(negedge clk);
        checks++; if (ren !== 1'b0)       begin errors++; $display("FAIL rst_ren got %b exp 0", ren); end
        checks++; if (roplen !== 2'b00)   begin errors++; $display("FAIL rst_roplen got %b exp 00", roplen); end
        checks++; if (fire !== 1'b0)      begin errors++; $display("FAIL rst_fire got %b exp 0", fire); end
        checks++; if (fire_last !== 1'b0) begin errors++; $display("FAIL rst_fire_last got %b exp 0", fire_last); end
        checks++; if (op_ready !== 1'b1)  begin errors++; $display("FAIL rst_op_ready got %b exp 1", op_ready); end
        checks++; if (wen !== 1'b0)       begin errors++; $display("FAIL rst_wen got %b exp 0", wen); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        pend_ropl = 2'b00;
        mon_en = 1;
    endtask

    // Three operands, two elements: reads at T1..T6, fires at T4 and T7.
    task automatic test_three_opnd;
        logic fr [1:8];
        logic fl [1:8];
        logic rd [1:8];
        drive_op(3, 8'd8, 8'd40, 8'd72, 1, 2);
        push_op(3, 8'd8, 8'd40, 8'd72, 1, 2);
        @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_t0 got %b exp 1", op_ready); end
        tick();
        op_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            fr[c] = fire;
            fl[c] = fire_last;
            rd[c] = op_ready;
            tick();
        end
        for (int c = 1; c <= 8; c++) begin
            checks++; if (fr[c] !== (c == 4 || c == 7)) begin errors++; $display("FAIL t1_fire T%0d got %b", c, fr[c]); end
            checks++; if (fl[c] !== (c == 7)) begin errors++; $display("FAIL t1_fire_last T%0d got %b", c, fl[c]); end
            checks++; if (rd[c] !== (c >= 7)) begin errors++; $display("FAIL t1_op_ready T%0d got %b", c, rd[c]); end
        end
    endtask

    // Single operand with address wrap: fires on four consecutive cycles.
    task automatic test_wrap;
        logic fr [1:6];
        logic fl [1:6];
        drive_op(1, 8'd254, 8'd0, 8'd0, 1, 4);
        push_op(1, 8'd254, 8'd0, 8'd0, 1, 4);
        tick();
        op_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            fr[c] = fire;
            fl[c] = fire_last;
            tick();
        end
        for (int c = 1; c <= 6; c++) begin
            checks++; if (fr[c] !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL t2_fire T%0d got %b", c, fr[c]); end
            checks++; if (fl[c] !== (c == 5)) begin errors++; $display("FAIL t2_fire_last T%0d got %b", c, fl[c]); end
        end
        wait_idle();
    endtask

    // Zero-length op is swallowed; the following op starts one cycle after its accept.
    task automatic test_vlen0;
        drive_op(2, 8'd1, 8'd2, 8'd3, 1, 0);
        tick();
        drive_op(2, 8'd10, 8'd20, 8'd0, 3, 2);
        push_op(2, 8'd10, 8'd20, 8'd0, 3, 2);
        @(negedge clk);
        checks++; if (ren !== 1'b0)      begin errors++; $display("FAIL t3_ren_after_vlen0 got %b exp 0", ren); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_after_vlen0 got %b exp 1", op_ready); end
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        checks++; if (ren !== 1'b1) begin errors++; $display("FAIL t3_first_ren got %b exp 1", ren); end
        tick();
        wait_idle();
    endtask

    // Op B held valid during op A: accepted on A's trailing fire, one idle read cycle.
    task automatic test_back_to_back;
        logic rn [1:10];
        logic fr [1:10];
        logic fl [1:10];
        int   acc_c;
        acc_c = 0;
        drive_op(2, 8'h10, 8'h80, 8'h00, 4, 2);
        push_op(2, 8'h10, 8'h80, 8'h00, 4, 2);
        push_op(3, 8'h30, 8'h50, 8'h70, 1, 1);
        tick();
        drive_op(3, 8'h30, 8'h50, 8'h70, 1, 1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            rn[c] = ren;
            fr[c] = fire;
            fl[c] = fire_last;
            if (op_valid && op_ready) acc_c = c;
            tick();
            if (acc_c == c) op_valid = 1'b0;
        end
        checks++; if (acc_c !== 5) begin errors++; $display("FAIL t4_accept_cycle got %0d exp 5", acc_c); end
        for (int c = 1; c <= 10; c++) begin
            checks++; if (rn[c] !== (c <= 4 || (c >= 6 && c <= 8))) begin errors++; $display("FAIL t4_ren T%0d got %b", c, rn[c]); end
            checks++; if (fr[c] !== (c == 3 || c == 5 || c == 9)) begin errors++; $display("FAIL t4_fire T%0d got %b", c, fr[c]); end
            checks++; if (fl[c] !== (c == 5 || c == 9)) begin errors++; $display("FAIL t4_fire_last T%0d got %b", c, fl[c]); end
        end
        wait_idle();
    endtask

    // Reset during element 1 drops the op: no ren, no fire, latches cleared.
    task automatic test_reset_midop;
        drive_op(2, 8'd0, 8'd100, 8'd0, 2, 5);
        push_op(2, 8'd0, 8'd100, 8'd0, 2, 5);
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #1;
        mon_en = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ren !== 1'b0)      begin errors++; $display("FAIL t5_ren got %b exp 0", ren); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL t5_op_ready got %b exp 1", op_ready); end
        checks++; if (roplen !== 2'b00)  begin errors++; $display("FAIL t5_roplen got %b exp 00", roplen); end
        checks++; if (fire !== 1'b0)     begin errors++; $display("FAIL t5_fire got %b exp 0", fire); end
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (fire !== 1'b0 || ren !== 1'b0) begin
                errors++;
                $display("FAIL t5_quiet cycle %0d fire %b ren %b exp 0 0", c, fire, ren);
            end
            tick();
        end
        exp_rd.delete();
        exp_fl.delete();
        pend_ropl = 2'b00;
        mon_en = 1;
    endtask

    // Write arbiter: directed cases, then every request pattern against a priority model.
    task automatic test_warb;
        logic [4:0] eg;
        logic [2:0] es;
        logic [7:0] ea;
        logic [7:0] sl [5];
        for (int i = 0; i < 5; i++) sl[i] = 8'(8'hA0 + 17 * i);
        waddr_in = {sl[4], sl[3], sl[2], sl[1], sl[0]};
        wreq = 5'b10110;
        #1;
        checks++; if (wgnt !== 5'b00010) begin errors++; $display("FAIL wa_gnt got %b exp 00010", wgnt); end
        checks++; if (wsel !== 3'd1)     begin errors++; $display("FAIL wa_sel got %0d exp 1", wsel); end
        checks++; if (waddr !== sl[1])   begin errors++; $display("FAIL wa_addr got %h exp %h", waddr, sl[1]); end
        checks++; if (wen !== 1'b1)      begin errors++; $display("FAIL wa_wen got %b exp 1", wen); end
        wreq = 5'b10000;
        #1;
        checks++; if (wsel !== 3'd4 || wgnt !== 5'b10000 || waddr !== sl[4]) begin
            errors++; $display("FAIL wa_viu sel %0d gnt %b addr %h exp 4 10000 %h", wsel, wgnt, waddr, sl[4]);
        end
        wreq = 5'b00000;
        #1;
        checks++; if (wen !== 1'b0 || wgnt !== 5'b0 || wsel !== 3'd0 || waddr !== 8'd0) begin
            errors++; $display("FAIL wa_idle wen %b gnt %b sel %0d addr %h exp all 0", wen, wgnt, wsel, waddr);
        end
        for (int p = 0; p < 32; p++) begin
            for (int i = 0; i < 5; i++) sl[i] = 8'($urandom_range(0, 255));
            waddr_in = {sl[4], sl[3], sl[2], sl[1], sl[0]};
            wreq = 5'(p);
            eg = '0; es = '0; ea = '0;
            for (int i = 4; i >= 0; i--) begin
                if (p[i]) begin
                    eg = 5'(1 << i);
                    es = 3'(i);
                    ea = sl[i];
                end
            end
            #1;
            checks++;
            if ({wen, wgnt, wsel, waddr} !== {(p != 0), eg, es, ea}) begin
                errors++;
                $display("FAIL wa_sweep req %b got wen %b gnt %b sel %0d addr %h exp %b %b %0d %h",
                         wreq, wen, wgnt, wsel, waddr, (p != 0), eg, es, ea);
            end
        end
        wreq = '0;
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 0;
        pend_ropl = 2'b00;
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_nopnd  = '0;
        op_addr0  = '0;
        op_addr1  = '0;
        op_addr2  = '0;
        op_stride = '0;
        op_vlen   = '0;
        wreq      = '0;
        waddr_in  = '0;
        tick();
        test_reset();
        test_three_opnd();
        test_wrap();
        test_vlen0();
        test_back_to_back();
        test_reset_midop();
        test_warb();
        checks++;
        if (exp_rd.size() != 0 || exp_fl.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected reads %0d fires %0d exp 0 0", exp_rd.size(), exp_fl.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vu_bank_seq.md
Name: vu_bank_seq

Overview:
- Per-bank port controller for the Banked8 VXU 1R1W bank register file.
- Read side: accepts one vector operation descriptor at a time and sequences the single read port over all elements and operands. It drives ren/raddr and the operand-latch enables (roplen), and pulses fire when a full operand set is presented to the functional unit.
- Write side: arbitrates the single write port among four writeback lanes and the VIU, driving wen/waddr/wsel.

Parameters:
- REGLEN_W, 8, bank register address width (256 entries).
- VLEN_W, 8, element count width.
- NWR, 5, write requesters (0–3 = wbl0–wbl3, 4 = VIU); also the wsel encoding.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  descriptor valid.
- op_ready  out  1  sequencer can accept a descriptor.
- op_nopnd  in  2  operands per element (1..3).
- op_addr0/op_addr1/op_addr2  in  REGLEN_W each  element-0 operand base addresses.
- op_stride  in  REGLEN_W  per-element address increment.
- op_vlen  in  VLEN_W  element count.
- ren  out  1  regfile read enable.
- raddr  out  REGLEN_W  regfile read address.
- roplen  out  2  operand latch enables (bit0→ropl0, bit1→ropl1).
- fire  out  1  operand set complete (ropl0, ropl1, rdata valid for FU).
- fire_last  out  1  qualifies fire: last element of the op.
- wreq  in  NWR  write requests.
- waddr_in  in  NWR*REGLEN_W  per-requester write addresses, requester i at slice i.
- wgnt  out  NWR  one-hot write grant.
- wen  out  1  regfile write enable.
- waddr  out  REGLEN_W  granted write address.
- wsel  out  3  granted requester index.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: ren=0, roplen=0, fire=0, fire_last=0, op_ready=1. Internal state returns to IDLE and all counters and the delay pipeline clear, including when reset hits mid-op; the in-flight op is dropped with no further fire.
- Regfile timing:
  - Read is synchronous: data for a ren in cycle T appears on rdata in T+1.
  - roplen[k] asserted in T+1 latches ropl at the end of T+1.
- FSM states: IDLE, READ.
  - IDLE: op_ready=1.
  - Accept occurs on op_valid && op_ready. Latch the descriptor and the running addresses a0..a2, and clear elem and opnd counters.
  - op_vlen==0 → stay IDLE; no ren, no fire.
  - op_nopnd==0 is treated as 1.
  - Otherwise → READ.
- READ: op_ready=0. Each cycle:
  - ren=1, raddr=a[opnd].
  - If opnd<nopnd-1: opnd++.
  - Else: opnd=0, elem++, and every a_k += stride, modulo 2^REGLEN_W (wrap, no saturation).
  - After the ren for the last operand of element vlen-1 → IDLE.
  - Back-to-back elements: no bubbles; element e+1's operand 0 issues in the cycle after element e's last operand.
- Delay pipeline (1-stage register, valid even after the FSM leaves READ):
  - Read of operand 0 at T with nopnd≥2 → roplen=01 at T+1.
  - Read of operand 1 at T with nopnd=3 → roplen=10 at T+1.
  - Read of the last operand at T → fire=1 at T+1; fire_last=1 if element vlen-1.
  - The last operand is never latched; the FU takes it from rdata.
- Latency: nopnd=3 → ren in T1,T2,T3 and fire in T4 relative to accept in T0.
- A new op may be accepted in the cycle the FSM returns to IDLE, i.e. the cycle carrying the previous op's trailing fire. Its first ren is issued one cycle later.
- Write arbitration (combinational, same cycle):
  - Fixed priority, lowest index wins.
  - wen = |wreq; wgnt is one-hot of the winner; wsel = winner index; waddr = the winner's slice.
  - With no request: wgnt=0, wsel=0, waddr=0.
  - Losers get no grant and must hold their request.
  - Read and write ports are independent. A same-address read and write in one cycle is not forwarded.

Decomposition:
- Shared package: REGLEN/VLEN widths, the wsel encoding constants (WSEL_WBL0..3=0..3, WSEL_VIU=4), and the roplen bit assignments.
- One sub-module, vu_bank_wport_arb: the fixed-priority write arbiter, parameterized by NWR.

Test Plan:
1. nopnd=3, addr0/1/2=8/40/72, stride=1, vlen=2:
   - raddr is 8,40,72,9,41,73 on consecutive cycles.
   - roplen is 01,10 after each first/second read.
   - fire in T4 and T7; fire_last only at T7; op_ready=1 again at T7.
2. nopnd=1, addr0=254, stride=1, vlen=4: raddr is 254,255,0,1 (wrap); fire on 4 consecutive cycles; roplen stays 0.
3. vlen=0 accept → no ren and no fire. A second op (nopnd=2) presented in the next cycle is accepted; its ren begins one cycle after accept.
4. Back-to-back ops: op B held valid during op A. B is accepted in the cycle of A's final fire, and B's first ren follows with exactly one idle read cycle.
5. Reset asserted during element 1 of a vlen=5 op: the next cycle shows ren=0, op_ready=1, no further fire, and roplen=0.
6. Write arbitration:
   - wreq=10110 → wgnt=00010, wsel=1, waddr = slice 1.
   - wreq=10000 → wsel=4 (VIU).
   - wreq=0 → wen=0.
